// File: rtl/extend_positive_signals.sv
// Pulse stretcher: holds new_signal_o high for EXTEND_CYCLES edges after the
// last edge that sampled signal_i high. Output is driven straight from a flop.
module extend_positive_signals #(
  parameter int unsigned EXTEND_CYCLES = 50,
  parameter int unsigned CNT_W         = $clog2(EXTEND_CYCLES + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic signal_i,
  output logic new_signal_o
);

  localparam logic [CNT_W-1:0] CntLoad = CNT_W'(EXTEND_CYCLES);
  localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             new_signal_q, new_signal_d;

  // Retrigger has priority; the counter saturates at zero and never wraps.
  always_comb begin
    cnt_d        = '0;
    new_signal_d = 1'b0;
    if (signal_i) begin
      cnt_d        = CntLoad;
      new_signal_d = 1'b1;
    end else if (cnt_q > CntOne) begin
      cnt_d        = cnt_q - CntOne;
      new_signal_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      new_signal_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      new_signal_q <= new_signal_d;
    end
  end

  assign new_signal_o = new_signal_q;

endmodule

// File: tb/tb_extend_positive_signals.sv
// Directed bench for extend_positive_signals: one default instance (50 cycles)
// and one EXTEND_CYCLES=1 instance, checked against an edge-index model.
module tb_extend_positive_signals;

  localparam int unsigned Ext50 = 50;
  localparam int unsigned Ext1  = 1;

  logic clk;
  logic rst_n;
  logic sig50, sig1;
  logic out50, out1;

  int checks = 0;
  int errors = 0;

  extend_positive_signals #(
    .EXTEND_CYCLES(Ext50)
  ) u_dut50 (
    .clk         (clk),
    .rst_n       (rst_n),
    .signal_i    (sig50),
    .new_signal_o(out50)
  );

  extend_positive_signals #(
    .EXTEND_CYCLES(Ext1)
  ) u_dut1 (
    .clk         (clk),
    .rst_n       (rst_n),
    .signal_i    (sig1),
    .new_signal_o(out1)
  );

  // 10-unit period: rising edges at t = 5, 15, 25 ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Model: remember the index of the most recent edge that sampled the input high.
  int edge_n = 0;
  int last50 = 0;
  int last1  = 0;
  bit has50  = 1'b0;
  bit has1   = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      has50 <= 1'b0;
      has1  <= 1'b0;
    end else begin
      edge_n <= edge_n + 1;
      if (sig50) begin
        has50  <= 1'b1;
        last50 <= edge_n + 1;
      end
      if (sig1) begin
        has1  <= 1'b1;
        last1 <= edge_n + 1;
      end
    end
  end

  function automatic logic model_out(bit has, int last, int n, int unsigned ext);
    return has && ((n - last) < int'(ext));
  endfunction

  always @(negedge clk) begin
    logic e50, e1;
    e50 = model_out(has50, last50, edge_n, Ext50);
    e1  = model_out(has1, last1, edge_n, Ext1);
    checks = checks + 2;
    if (out50 !== e50) begin
      errors = errors + 1;
      $display("FAIL model50 t=%0t: got %b expected %b", $time, out50, e50);
    end
    if (out1 !== e1) begin
      errors = errors + 1;
      $display("FAIL model1 t=%0t: got %b expected %b", $time, out1, e1);
    end
  end

  task automatic wait_until(input int t);
    if (t > $time) #(t - $time);
  endtask

  task automatic check(input string name, input logic act, input logic exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s t=%0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    sig50 = 1'b0;
    sig1  = 1'b0;
    #2;
    check("reset50", out50, 1'b0);
    check("reset1", out1, 1'b0);
    wait_until(10);
    rst_n = 1'b1;

    // 20-unit pulse sampled at edges 45 and 55 -> high 45..555
    wait_until(40);  sig50 = 1'b1;
    wait_until(44);  check("pulse_pre_rise", out50, 1'b0);
    wait_until(50);  check("pulse_rise", out50, 1'b1);
    wait_until(60);  sig50 = 1'b0;
    wait_until(550); check("pulse_tail", out50, 1'b1);
    wait_until(560); check("pulse_fall", out50, 1'b0);

    // Long input: last high edge 955 -> falls at 1455
    wait_until(760);  sig50 = 1'b1;
    wait_until(770);  check("long_rise", out50, 1'b1);
    wait_until(960);  sig50 = 1'b0;
    wait_until(1450); check("long_tail", out50, 1'b1);
    wait_until(1460); check("long_fall", out50, 1'b0);

    // Short pulse after idle: high 1965..2475, then idle
    wait_until(1960); sig50 = 1'b1;
    wait_until(1970); check("short_rise", out50, 1'b1);
    wait_until(1980); sig50 = 1'b0;
    wait_until(2470); check("short_tail", out50, 1'b1);
    wait_until(2480); check("short_fall", out50, 1'b0);
    wait_until(6980); check("idle_low", out50, 1'b0);

    // Retrigger 30 cycles apart: continuous high 7005..7805
    wait_until(7000); sig50 = 1'b1;
    wait_until(7010); sig50 = 1'b0;
    wait_until(7300); check("retrig_mid", out50, 1'b1);
    sig50 = 1'b1;
    wait_until(7310); sig50 = 1'b0;
    wait_until(7510); check("retrig_no_gap", out50, 1'b1);
    wait_until(7800); check("retrig_tail", out50, 1'b1);
    wait_until(7810); check("retrig_fall", out50, 1'b0);

    // Reset 20 cycles into an extension, input high during reset is ignored
    wait_until(8000); sig50 = 1'b1;
    wait_until(8010); sig50 = 1'b0;
    wait_until(8200); check("pre_reset_high", out50, 1'b1);
    wait_until(8202); rst_n = 1'b0;
    #1;               check("async_reset", out50, 1'b0);
    wait_until(8210); sig50 = 1'b1;
    wait_until(8220); check("sig_in_reset", out50, 1'b0);
    sig50 = 1'b0;
    wait_until(8230); rst_n = 1'b1;
    wait_until(8300); check("no_resume", out50, 1'b0);
    wait_until(8400); sig50 = 1'b1;
    wait_until(8402); check("post_reset_pre", out50, 1'b0);
    wait_until(8410); check("post_reset_rise", out50, 1'b1);
    sig50 = 1'b0;

    // EXTEND_CYCLES=1: plain one-edge delay
    wait_until(9000); sig1 = 1'b1;
    wait_until(9002); check("e1_pre", out1, 1'b0);
    wait_until(9010); check("e1_rise", out1, 1'b1);
    wait_until(9030); check("e1_hold", out1, 1'b1);
    sig1 = 1'b0;
    wait_until(9040); check("e1_fall", out1, 1'b0);
    wait_until(9100); sig1 = 1'b1;
    wait_until(9110); check("e1_one_high", out1, 1'b1);
    sig1 = 1'b0;
    wait_until(9120); check("e1_one_fall", out1, 1'b0);

    wait_until(9500);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
